// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants: default RX FIFO depth and the UART
//               register map offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;

    localparam logic [3:0] UART_RX_DATA_ADDR  = 4'h0;
    localparam logic [3:0] UART_RX_AVAIL_ADDR = 4'h4;
    localparam logic [3:0] UART_RX_COUNT_ADDR = 4'h8;
    localparam logic [3:0] UART_OVF_ADDR      = 4'hC;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH x DATA_W storage array, one write port, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are intentionally left unreset; validity is tracked by the
    // pointer/count logic in the parent.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive FIFO, first-word fall-through, drop-on-full with
//               sticky overflow flag, flush and overflow clear controls.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_data_valid,
    output logic                     rx_data_ready,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic [DATA_W-1:0]        data_o,
    output logic                     avail,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    logic               w_full;
    logic               w_avail;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_we;
    logic [DATA_W-1:0]  w_head;

    assign w_full  = (r_count == c_depth);
    assign w_avail = (r_count != '0);
    assign w_pop   = pop && w_avail;
    // A pop in the same cycle frees the slot the incoming byte lands in.
    assign w_push  = rx_data_valid && (!w_full || w_pop);
    assign w_drop  = rx_data_valid && w_full && !w_pop;
    assign w_we    = w_push && !flush;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (c_ptr_w)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (rx_data),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rx_data_ready = 1'b1;
    assign data_o        = w_avail ? w_head : '0;
    assign avail         = w_avail;
    assign full          = w_full;
    assign count         = r_count;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire
